// File: rtl/eth_rx_stat_if.sv
// Avalon-ST receive stream carrying TSE MAC RX beats into eth_rx_stat.
// Byte 0 of each beat sits in the MSBs of data; empty is only meaningful on eop.
interface eth_rx_stat_if #(
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2
);
  logic [DATA_W-1:0]  data;
  logic               valid;
  logic               sop;
  logic               eop;
  logic [EMPTY_W-1:0] empty;
  logic [5:0]         error;
  logic               ready;

  modport master (output data, valid, sop, eop, empty, error, input ready);
  modport slave  (input data, valid, sop, eop, empty, error, output ready);
endinterface

// File: rtl/eth_rx_stat.sv
// RX statistics and activity LEDs for the TSE MAC Avalon-ST stream.
// Optional broadcast counting is built when ETH_RX_STAT_BCAST_EN is defined.
module eth_rx_stat #(
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2,
  parameter int CNT_W   = 32,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int STRETCH = 5000000,
  parameter int LED_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  eth_rx_stat_if.slave       rx,
  input  logic               clr,
  output logic [CNT_W-1:0]   pkt_cnt,
  output logic [CNT_W-1:0]   byte_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   runt_cnt,
  output logic [CNT_W-1:0]   giant_cnt,
  output logic [CNT_W-1:0]   frm_cnt,
  output logic [CNT_W-1:0]   bcast_cnt,
  output logic [15:0]        last_len,
  output logic               stat_vld,
  output logic [LED_W-1:0]   led
);
  localparam int BYTES = DATA_W / 8;
  localparam int TMR_W = $clog2(STRETCH + 1);
  localparam int SUM_W = ((CNT_W > 16) ? CNT_W : 16) + 1;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t           state, state_nxt;
  logic [15:0]      len, len_nxt, fin_len, beat_bytes;
  logic [16:0]      len_sum;
  logic             ready_q, accept, fin, fin_err, fin_runt, fin_giant, frm_evt, err_evt;
  logic [SUM_W-1:0] byte_sum;
  logic [CNT_W-1:0] byte_nxt;
  logic [TMR_W-1:0] act_tmr, err_tmr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + CNT_W'(1) : v;
  endfunction

  assign rx.ready   = ready_q;
  assign accept     = rx.valid & ready_q;
  assign beat_bytes = rx.eop ? 16'(BYTES) - 16'(rx.empty) : 16'(BYTES);
  assign len_sum    = {1'b0, len} + {1'b0, beat_bytes};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      len   <= '0;
    end else begin
      state <= state_nxt;
      len   <= len_nxt;
    end
  end

  // A sop always starts a fresh packet; a sop seen mid-packet aborts the old one.
  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    fin       = 1'b0;
    fin_len   = beat_bytes;
    frm_evt   = 1'b0;
    if (accept) begin
      if (rx.sop) begin
        frm_evt = (state == IN_PKT);
        if (rx.eop) begin
          fin       = 1'b1;
          state_nxt = IDLE;
        end else begin
          len_nxt   = beat_bytes;
          state_nxt = IN_PKT;
        end
      end else if (state == IDLE) begin
        frm_evt = 1'b1;
      end else begin
        fin_len = len_sum[16] ? 16'hFFFF : len_sum[15:0];
        if (rx.eop) begin
          fin       = 1'b1;
          state_nxt = IDLE;
        end else begin
          len_nxt = fin_len;
        end
      end
    end
  end

  assign fin_err   = |rx.error;
  assign fin_runt  = fin_len < 16'(MIN_LEN);
  assign fin_giant = fin_len > 16'(MAX_LEN);
  assign err_evt   = frm_evt | (fin & (fin_err | fin_runt | fin_giant));
  assign byte_sum  = SUM_W'(byte_cnt) + SUM_W'(fin_len);
  assign byte_nxt  = (byte_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : byte_sum[CNT_W-1:0];

  // Clear has priority over a coincident finalize, but the stat_vld pulse still fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt   <= '0;
      byte_cnt  <= '0;
      err_cnt   <= '0;
      runt_cnt  <= '0;
      giant_cnt <= '0;
      frm_cnt   <= '0;
      last_len  <= '0;
      stat_vld  <= 1'b0;
    end else begin
      stat_vld <= fin;
      if (clr) begin
        pkt_cnt   <= '0;
        byte_cnt  <= '0;
        err_cnt   <= '0;
        runt_cnt  <= '0;
        giant_cnt <= '0;
        frm_cnt   <= '0;
        last_len  <= '0;
      end else begin
        frm_cnt <= sat_inc(frm_cnt, frm_evt);
        if (fin) begin
          pkt_cnt   <= sat_inc(pkt_cnt, 1'b1);
          byte_cnt  <= byte_nxt;
          err_cnt   <= sat_inc(err_cnt, fin_err);
          runt_cnt  <= sat_inc(runt_cnt, fin_runt);
          giant_cnt <= sat_inc(giant_cnt, fin_giant);
          last_len  <= fin_len;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_tmr <= '0;
      err_tmr <= '0;
    end else begin
      if (fin)                act_tmr <= TMR_W'(STRETCH);
      else if (act_tmr != '0) act_tmr <= act_tmr - TMR_W'(1);
      if (err_evt)            err_tmr <= TMR_W'(STRETCH);
      else if (err_tmr != '0) err_tmr <= err_tmr - TMR_W'(1);
    end
  end

  assign led[0] = |act_tmr;
  assign led[1] = |err_tmr;
  if (LED_W > 2) begin : g_led_cnt
    assign led[LED_W-1:2] = pkt_cnt[LED_W-3:0];
  end

`ifdef ETH_RX_STAT_BCAST_EN
  logic [2:0] bidx, bidx_nxt;
  logic       bc_ok, bc_ok_nxt, bc_upd;
  int         bc_base, bc_seen;

  // bidx counts destination bytes seen so far (capped at 6) across beats.
  always_comb begin
    bc_base   = rx.sop ? 0 : int'(bidx);
    bc_ok_nxt = rx.sop | bc_ok;
    for (int j = 0; j < BYTES; j++) begin
      if ((bc_base + j) < 6 && j < int'(beat_bytes) && rx.data[DATA_W-1-8*j -: 8] != 8'hFF)
        bc_ok_nxt = 1'b0;
    end
    bc_seen  = bc_base + int'(beat_bytes);
    bidx_nxt = (bc_seen > 6) ? 3'd6 : 3'(bc_seen);
    bc_upd   = accept & (rx.sop | (state == IN_PKT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bidx  <= '0;
      bc_ok <= 1'b0;
    end else if (bc_upd) begin
      bidx  <= bidx_nxt;
      bc_ok <= bc_ok_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      bcast_cnt <= '0;
    else if (clr) bcast_cnt <= '0;
    else if (fin) bcast_cnt <= sat_inc(bcast_cnt, bc_ok_nxt && (bidx_nxt == 3'd6));
  end
`else
  assign bcast_cnt = '0;
`endif
endmodule

// File: tb/tb_eth_rx_stat.sv
// Directed bench for eth_rx_stat: a 32-bit counter instance and an 8-bit one
// fed from the same stream so saturation can be reached quickly.
module tb_eth_rx_stat;
  localparam int DATA_W  = 32;
  localparam int EMPTY_W = 2;
`ifdef ETH_RX_STAT_BCAST_EN
  localparam longint BC = 1;
`else
  localparam longint BC = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  eth_rx_stat_if #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) m_if ();
  eth_rx_stat_if #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) s_if ();

  assign s_if.data  = m_if.data;
  assign s_if.valid = m_if.valid;
  assign s_if.sop   = m_if.sop;
  assign s_if.eop   = m_if.eop;
  assign s_if.empty = m_if.empty;
  assign s_if.error = m_if.error;

  logic [31:0] m_pkt, m_byte, m_err, m_runt, m_giant, m_frm, m_bcast;
  logic [15:0] m_last;
  logic        m_vld;
  logic [3:0]  m_led;
  logic [7:0]  s_pkt, s_byte, s_err, s_runt, s_giant, s_frm, s_bcast;
  logic [15:0] s_last;
  logic        s_vld;
  logic [3:0]  s_led;

  eth_rx_stat #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CNT_W(32), .MIN_LEN(64),
                .MAX_LEN(1518), .STRETCH(10), .LED_W(4)) dut_main (
    .clk(clk), .rst(rst), .rx(m_if.slave), .clr(clr),
    .pkt_cnt(m_pkt), .byte_cnt(m_byte), .err_cnt(m_err), .runt_cnt(m_runt),
    .giant_cnt(m_giant), .frm_cnt(m_frm), .bcast_cnt(m_bcast),
    .last_len(m_last), .stat_vld(m_vld), .led(m_led));

  eth_rx_stat #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CNT_W(8), .MIN_LEN(64),
                .MAX_LEN(1518), .STRETCH(10), .LED_W(4)) dut_small (
    .clk(clk), .rst(rst), .rx(s_if.slave), .clr(clr),
    .pkt_cnt(s_pkt), .byte_cnt(s_byte), .err_cnt(s_err), .runt_cnt(s_runt),
    .giant_cnt(s_giant), .frm_cnt(s_frm), .bcast_cnt(s_bcast),
    .last_len(s_last), .stat_vld(s_vld), .led(s_led));

  typedef struct {
    int          nbytes;
    logic [5:0]  err;
    bit          orphan;
    int          abort_beats;
    longint      exp_pkt, exp_byte, exp_err, exp_runt, exp_giant, exp_frm, exp_last;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] pkt_byte(input int k, input logic [47:0] dest);
    if (k < 6) return dest[47-8*k -: 8];
    return k[7:0];
  endfunction

  task automatic driveBeat(input logic [31:0] d, input logic s, input logic e,
                           input logic [1:0] emp, input logic [5:0] er);
    m_if.data  = d;
    m_if.sop   = s;
    m_if.eop   = e;
    m_if.empty = emp;
    m_if.error = er;
    m_if.valid = 1'b1;
    @(posedge clk);
    #1;
    m_if.valid = 1'b0;
    m_if.sop   = 1'b0;
    m_if.eop   = 1'b0;
    m_if.empty = '0;
    m_if.error = '0;
  endtask

  // One packet, back-to-back beats; optional clr on a beat and an idle garbage cycle.
  task automatic applyStimulus(input int n, input logic [5:0] er, input logic [47:0] dest,
                               input int clr_beat, input int gap_beat);
    int          beats;
    logic [31:0] d;
    beats = (n + 3) / 4;
    for (int b = 0; b < beats; b++) begin
      if (b == gap_beat) begin
        m_if.sop   = 1'b1;
        m_if.eop   = 1'b1;
        m_if.error = 6'h3F;
        @(posedge clk);
        #1;
        m_if.sop   = 1'b0;
        m_if.eop   = 1'b0;
        m_if.error = '0;
      end
      for (int i = 0; i < 4; i++) d[31-8*i -: 8] = pkt_byte(b*4 + i, dest);
      clr = (b == clr_beat);
      driveBeat(d, b == 0, b == beats - 1,
                (b == beats - 1) ? 2'(beats*4 - n) : 2'd0,
                (b == beats - 1) ? er : 6'h00);
      clr = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{64,   6'h00, 1'b0, 0, 1,   64, 0, 0, 0, 0,   64};
    vecs[1] = '{61,   6'h00, 1'b0, 0, 2,  125, 0, 1, 0, 0,   61};
    vecs[2] = '{1519, 6'h00, 1'b0, 0, 3, 1644, 0, 1, 1, 0, 1519};
    vecs[3] = '{100,  6'h00, 1'b1, 0, 4, 1744, 0, 1, 1, 1,  100};
    vecs[4] = '{64,   6'h00, 1'b0, 3, 5, 1808, 0, 1, 1, 2,   64};
    vecs[5] = '{8,    6'h02, 1'b0, 0, 6, 1816, 1, 2, 1, 2,    8};
    vecs[6] = '{1518, 6'h00, 1'b0, 0, 7, 3334, 1, 2, 1, 2, 1518};
    vecs[7] = '{63,   6'h00, 1'b0, 0, 8, 3397, 1, 3, 1, 2,   63};
    vecs[8] = '{1,    6'h00, 1'b0, 0, 9, 3398, 1, 4, 1, 2,    1};

    m_if.data = '0; m_if.valid = 1'b0; m_if.sop = 1'b0; m_if.eop = 1'b0;
    m_if.empty = '0; m_if.error = '0;

    #2;
    checkOutput("reset ready", m_if.ready, 0);
    checkOutput("reset pkt", m_pkt, 0);
    checkOutput("reset last", m_last, 0);
    checkOutput("reset vld", m_vld, 0);
    checkOutput("reset led", m_led, 0);
    #6 rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("ready after reset", m_if.ready, 1);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].orphan) driveBeat(32'hDEADBEEF, 1'b0, 1'b0, 2'd0, 6'h00);
      for (int b = 0; b < vecs[i].abort_beats; b++)
        driveBeat(32'h11223344, b == 0, 1'b0, 2'd0, 6'h00);
      applyStimulus(vecs[i].nbytes, vecs[i].err, 48'h0, -1, -1);
      checkOutput($sformatf("v%0d pkt", i), m_pkt, vecs[i].exp_pkt);
      checkOutput($sformatf("v%0d byte", i), m_byte, vecs[i].exp_byte);
      checkOutput($sformatf("v%0d err", i), m_err, vecs[i].exp_err);
      checkOutput($sformatf("v%0d runt", i), m_runt, vecs[i].exp_runt);
      checkOutput($sformatf("v%0d giant", i), m_giant, vecs[i].exp_giant);
      checkOutput($sformatf("v%0d frm", i), m_frm, vecs[i].exp_frm);
      checkOutput($sformatf("v%0d last", i), m_last, vecs[i].exp_last);
      checkOutput($sformatf("v%0d vld", i), m_vld, 1);
      checkOutput($sformatf("v%0d led0", i), m_led[0], 1);
      checkOutput($sformatf("v%0d ledcnt", i), m_led[3:2], vecs[i].exp_pkt % 4);
    end

    // Last table packet was a 1-byte runt: both LEDs run exactly 10 cycles.
    repeat (9) begin @(posedge clk); #1; end
    checkOutput("stretch vld drop", m_vld, 0);
    checkOutput("stretch act 9", m_led[0], 1);
    checkOutput("stretch err 9", m_led[1], 1);
    @(posedge clk);
    #1;
    checkOutput("stretch act 10", m_led[0], 0);
    checkOutput("stretch err 10", m_led[1], 0);

    applyStimulus(64, 6'h02, 48'h0, 15, -1);
    checkOutput("clr+fin pkt", m_pkt, 0);
    checkOutput("clr+fin byte", m_byte, 0);
    checkOutput("clr+fin err", m_err, 0);
    checkOutput("clr+fin runt", m_runt, 0);
    checkOutput("clr+fin giant", m_giant, 0);
    checkOutput("clr+fin frm", m_frm, 0);
    checkOutput("clr+fin last", m_last, 0);
    checkOutput("clr+fin vld", m_vld, 1);
    applyStimulus(64, 6'h02, 48'h0, 3, 7);
    checkOutput("midclr pkt", m_pkt, 1);
    checkOutput("midclr byte", m_byte, 64);
    checkOutput("midclr err", m_err, 1);
    checkOutput("midclr frm", m_frm, 0);
    checkOutput("midclr last", m_last, 64);
    checkOutput("midclr led1", m_led[1], 1);

    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    checkOutput("small cleared", s_pkt, 0);
    for (int p = 0; p < 300; p++) applyStimulus(4, 6'h00, 48'h0, -1, -1);
    checkOutput("sat pkt", s_pkt, 255);
    checkOutput("sat byte", s_byte, 255);
    checkOutput("sat runt", s_runt, 255);
    checkOutput("sat ledcnt", s_led[3:2], 3);
    checkOutput("wide pkt", m_pkt, 300);
    checkOutput("wide byte", m_byte, 1200);

    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    applyStimulus(64, 6'h00, 48'hFFFF_FFFF_FFFF, -1, -1);
    checkOutput("bcast all FF", m_bcast, BC);
    applyStimulus(64, 6'h00, 48'hFFFF_FFFF_FFFE, -1, -1);
    checkOutput("bcast FE", m_bcast, BC);
    applyStimulus(4, 6'h00, 48'hFFFF_FFFF_FFFF, -1, -1);
    checkOutput("bcast short", m_bcast, BC);
    applyStimulus(6, 6'h00, 48'hFFFF_FFFF_FFFF, -1, -1);
    checkOutput("bcast 6 bytes", m_bcast, 2 * BC);
    checkOutput("bcast pkt", m_pkt, 4);

    for (int b = 0; b < 3; b++) driveBeat(32'hA5A5A5A5, b == 0, 1'b0, 2'd0, 6'h00);
    rst = 1'b1;
    #2;
    checkOutput("midrst ready", m_if.ready, 0);
    checkOutput("midrst pkt", m_pkt, 0);
    checkOutput("midrst bcast", m_bcast, 0);
    checkOutput("midrst led", m_led, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst ready back", m_if.ready, 1);
    driveBeat(32'hA5A5A5A5, 1'b0, 1'b1, 2'd0, 6'h00);
    checkOutput("midrst frm", m_frm, 1);
    checkOutput("midrst no pkt", m_pkt, 0);
    checkOutput("midrst no vld", m_vld, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
